// File: rtl/mul_rr_scheduler_if.sv
// Client and datapath signal bundle for mul_rr_scheduler.
// master = client/datapath side, slave = scheduler side.
interface mul_rr_scheduler_if #(
  parameter int W     = 4,
  parameter int RES_W = 16
);
  logic             req0;
  logic [W-1:0]     a0;
  logic [W-1:0]     b0;
  logic             req1;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  logic [W-1:0]     dp_a;
  logic [W-1:0]     dp_b;
  logic             dp_load;
  logic             dp_add;
  logic [RES_W-1:0] dp_result;
  logic [RES_W-1:0] result;
  logic             done0;
  logic             done1;
  logic             err0;
  logic             err1;

  modport master (
    output req0, a0, b0, req1, a1, b1, dp_result,
    input  dp_a, dp_b, dp_load, dp_add, result, done0, done1, err0, err1
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, dp_result,
    output dp_a, dp_b, dp_load, dp_add, result, done0, done1, err0, err1
  );
endinterface

// File: rtl/mul_rr_scheduler.sv
// Two-client round-robin scheduler for a repeated-addition multiply datapath.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the datapath and complete with result 0.
module mul_rr_scheduler #(
  parameter int W     = 4,
  parameter int RES_W = 16
) (
  input logic               clk,
  input logic               reset,
  mul_rr_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_CAPT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_cnt;
  logic [W-1:0]     w_cnt_nxt;
  logic [W-1:0]     r_dp_a;
  logic [W-1:0]     r_dp_b;
  logic             r_gnt;
  logic             r_last;
  logic             r_arm0;
  logic             r_arm1;
  logic             r_dp_load;
  logic             r_dp_add;
  logic             r_capt;
  logic             r_done0;
  logic             r_done1;
  logic             r_err0;
  logic             r_err1;
  logic [RES_W-1:0] r_result;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_any;
  logic             w_win;
  logic [W-1:0]     w_win_a;
  logic [W-1:0]     w_win_b;
  logic             w_req_g;
  logic             w_grant;
  logic             w_load_nxt;
  logic             w_add_nxt;
  logic             w_capt_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;

`ifdef MUL_ZERO_BYPASS_EN
  logic             r_zero;
  logic             w_zero;
`endif

  assign w_elig0 = bus.req0 & r_arm0;
  assign w_elig1 = bus.req1 & r_arm1;
  assign w_any   = w_elig0 | w_elig1;
  // Contention goes to whoever was not served last; otherwise the lone eligible one.
  assign w_win   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  assign w_win_a = w_win ? bus.a1 : bus.a0;
  assign w_win_b = w_win ? bus.b1 : bus.b0;
  assign w_req_g = r_gnt ? bus.req1 : bus.req0;

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero  = (w_win_a == '0) || (w_win_b == '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_load_nxt  = 1'b0;
    w_add_nxt   = 1'b0;
    w_capt_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant   = 1'b1;
          w_cnt_nxt = w_win_b;
`ifdef MUL_ZERO_BYPASS_EN
          w_state_nxt = w_zero ? S_DONE : S_LOAD;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        if (!w_req_g) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_load_nxt  = 1'b1;
          w_state_nxt = (r_cnt != '0) ? S_ADD : S_CAPT;
        end
      end
      S_ADD: begin
        if (!w_req_g) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_add_nxt = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == W'(1)) begin
            w_state_nxt = S_CAPT;
          end
        end
      end
      S_CAPT: begin
        w_capt_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Strobes are registered, so each one trails its state by a cycle; the capture
  // strobe therefore lands after the last dp_add has reached the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dp_load <= 1'b0;
      r_dp_add  <= 1'b0;
      r_capt    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      r_dp_load <= w_load_nxt;
      r_dp_add  <= w_add_nxt;
      r_capt    <= w_capt_nxt;
      r_done0   <= w_done_nxt & ~r_gnt;
      r_done1   <= w_done_nxt & r_gnt;
      r_err0    <= w_err_nxt & ~r_gnt;
      r_err1    <= w_err_nxt & r_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt  <= 1'b0;
      r_dp_a <= '0;
      r_dp_b <= '0;
`ifdef MUL_ZERO_BYPASS_EN
      r_zero <= 1'b0;
`endif
    end else if (w_grant) begin
      r_gnt  <= w_win;
      r_dp_a <= w_win_a;
      r_dp_b <= w_win_b;
`ifdef MUL_ZERO_BYPASS_EN
      r_zero <= w_zero;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
      r_arm0 <= 1'b1;
      r_arm1 <= 1'b1;
    end else begin
      if (w_done_nxt) begin
        r_last <= r_gnt;
      end
      // Dropping req re-arms and wins over the disarm of a same-cycle completion.
      if (!bus.req0) begin
        r_arm0 <= 1'b1;
      end else if (w_done_nxt && !r_gnt) begin
        r_arm0 <= 1'b0;
      end
      if (!bus.req1) begin
        r_arm1 <= 1'b1;
      end else if (w_done_nxt && r_gnt) begin
        r_arm1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else if (r_capt) begin
      r_result <= bus.dp_result;
`ifdef MUL_ZERO_BYPASS_EN
    end else if ((r_state == S_DONE) && r_zero) begin
      r_result <= '0;
`endif
    end
  end

  assign bus.dp_a    = r_dp_a;
  assign bus.dp_b    = r_dp_b;
  assign bus.dp_load = r_dp_load;
  assign bus.dp_add  = r_dp_add;
  assign bus.result  = r_result;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.err0    = r_err0;
  assign bus.err1    = r_err1;

endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
- Shares the single repeated-addition multiply datapath between two requesters.
- Arbitrates round-robin, latches the winner's operands, and drives the datapath's load and add enables for B iterations.
- Captures the product and returns it with a per-requester done pulse.
- Sits between client logic and the multiply datapath, replacing the single-user start/done FSM when two clients need the multiplier.

Parameters:
- W, 4, operand width of A and B; also the width of the iteration counter.
- RES_W, 16, result width; must be >= 2*W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request; held high until done0 or until abandoned
- a0  input  W  requester 0 operand A
- b0  input  W  requester 0 operand B
- req1  input  1  requester 1 request
- a1  input  W  requester 1 operand A
- b1  input  W  requester 1 operand B
- dp_a  output  W  latched operand A to the datapath
- dp_b  output  W  latched operand B to the datapath
- dp_load  output  1  one-cycle pulse: datapath clears its accumulator and loads dp_a
- dp_add  output  1  one pulse per iteration: accumulator += dp_a
- dp_result  input  RES_W  datapath accumulator value
- result  output  RES_W  registered product of the last completed request
- done0  output  1  one-cycle completion pulse for requester 0
- done1  output  1  one-cycle completion pulse for requester 1
- err0  output  1  one-cycle abort pulse for requester 0
- err1  output  1  one-cycle abort pulse for requester 1

Behaviour:
- Reset values:
  - State = IDLE.
  - dp_a, dp_b, result, iteration counter = 0.
  - dp_load, dp_add, done*, err* = 0.
  - Round-robin pointer favours req0.
  - Both arm bits = 1.
- Reset asserted mid-operation aborts the operation silently: no done, no err.
- States are IDLE, LOAD, ADD, CAPT, DONE. All outputs are Moore/registered.
- IDLE:
  - A requester is eligible when reqN=1 and armN=1.
  - One eligible requester: grant it.
  - Both eligible: grant the one not served last. The pointer updates only on DONE; an abort does not update it.
  - On grant: latch dp_a/dp_b from the winner, set counter = b, record the grant index, go to LOAD.
- LOAD: dp_load=1 for exactly one cycle. Next state is ADD if counter != 0, else CAPT.
- ADD:
  - dp_add=1 every cycle; counter decrements each cycle.
  - Leave for CAPT on the cycle the counter reaches 0, so there are exactly b dp_add pulses.
- CAPT: result <= dp_result at the end of this cycle; go to DONE.
- DONE:
  - doneN=1 for the granted requester only, for one cycle.
  - Set armN=0, update the pointer, go to IDLE.
- Latency: with the grant sampled at edge k, doneN is high during the cycle starting at edge k+b+3. With b=0, doneN is high at edge k+3 and dp_add never pulses.
- Re-arm: armN returns to 1 on any cycle where reqN=0. A requester holding req high after done is not served again until it has dropped req for at least one cycle.
- Abort:
  - If the granted reqN is 0 in LOAD or ADD, return to IDLE.
  - errN=1 during the next cycle; result is unchanged and no done is issued.
  - Operand changes on aN/bN after the grant are ignored.
- Arithmetic: a product of at most (2^W-1)^2 fits in RES_W, so no overflow handling is needed.
- Only one of done0/done1/err0/err1 is ever high in a given cycle.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - If the winner's a==0 or b==0 at grant, go IDLE -> DONE directly with result <= 0.
  - No dp_load or dp_add pulses; done is high 1 cycle after the grant edge.
  - Arbitration and pointer behaviour are unchanged.
- Undefined: zero operands take the normal LOAD/ADD/CAPT path. a=0 gives result 0 via the datapath; b=0 gives LOAD then CAPT.

Test Plan:
- Single request: req0 with a0=3, b0=5, req1=0 -> one dp_load, 5 dp_add pulses, result=15, done0 at grant+8, done1 never asserts.
- Simultaneous: req0 (a=2, b=3) and req1 (a=4, b=4) both high from reset -> req0 served first (result 6), then req1 (result 16), no cycle gap beyond IDLE.
- Fairness: req0 and req1 both held high and re-pulsed low for 1 cycle after each done, over 6 grants -> grants alternate 0,1,0,1,0,1.
- Boundary b=0: req1 with a1=9, b1=0 -> zero dp_add pulses, result=0, done1 at grant+3. With MUL_ZERO_BYPASS_EN: no dp_load, done1 at grant+1.
- Max operands: a0=15, b0=15 -> 15 dp_add pulses, result=225.
- Abort and reset: req0 (a=7, b=10) dropped after 4 dp_add pulses -> err0 one cycle, result holds its prior value, no done0. Separately, reset asserted during ADD -> all outputs 0 next cycle, and a later req0 is granted normally.
